// File: rtl/ac_zone_ctrl.sv
// ac_zone_ctrl: heat/cool zone controller with runtime setpoint and hysteresis,
// minimum on/off dwell timers and a lockout indicator.
// Optional feature macro: AC_FAN_EN adds the fan output with post-run overrun.
module ac_zone_ctrl #(
    parameter int TEMP_W      = 5,
    parameter int HYST_W      = 3,
    parameter int DWELL_W     = 8,
    parameter int MIN_ON      = 4,
    parameter int MIN_OFF     = 3,
    parameter int FAN_OVERRUN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [TEMP_W-1:0] temperature,
    input  logic [TEMP_W-1:0] setpoint,
    input  logic [HYST_W-1:0] hyst,
    output logic              heating,
    output logic              cooling,
    output logic              idle,
    output logic              locked
`ifdef AC_FAN_EN
    ,
    output logic              fan
`endif
);

    localparam int EW = TEMP_W + 1;
    localparam logic [DWELL_W-1:0] ON_LIM  = DWELL_W'(MIN_ON - 1);
    localparam logic [DWELL_W-1:0] OFF_LIM = DWELL_W'(MIN_OFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAT = 2'b01,
        ST_COOL = 2'b10
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] next_dwell;

    logic [EW-1:0] temp_ext;
    logic [EW-1:0] sp_ext;
    logic [EW-1:0] hyst_ext;
    logic          heat_dem;
    logic          cool_dem;

    // Demand detection; compares are one bit wider so temperature+hyst never wraps.
    always_comb begin
        temp_ext = {1'b0, temperature};
        sp_ext   = {1'b0, setpoint};
        hyst_ext = EW'(hyst);
        heat_dem = ((temp_ext + hyst_ext) <= sp_ext) && (temp_ext < sp_ext);
        cool_dem = (temp_ext >= (sp_ext + hyst_ext)) && (temp_ext > sp_ext);
    end

    // Next-state and dwell logic; dwell restarts on any state change and saturates otherwise.
    always_comb begin
        next_state = ST_IDLE;
        next_dwell = '0;
        if (!enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_IDLE;
                    if (heat_dem && (dwell >= OFF_LIM)) begin
                        next_state = ST_HEAT;
                    end else if (cool_dem && (dwell >= OFF_LIM)) begin
                        next_state = ST_COOL;
                    end
                end
                ST_HEAT: begin
                    next_state = ST_HEAT;
                    if ((temperature >= setpoint) && (dwell >= ON_LIM)) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_COOL: begin
                    next_state = ST_COOL;
                    if ((temperature <= setpoint) && (dwell >= ON_LIM)) begin
                        next_state = ST_IDLE;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
            if (next_state != state) begin
                next_dwell = '0;
            end else if (&dwell) begin
                next_dwell = dwell;
            end else begin
                next_dwell = dwell + DWELL_W'(1);
            end
        end
    end

    // State and dwell registers; reset leaves the off-time already satisfied.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            dwell <= '1;
        end else begin
            state <= next_state;
            dwell <= next_dwell;
        end
    end

    assign heating = (state == ST_HEAT);
    assign cooling = (state == ST_COOL);
    assign idle    = (state == ST_IDLE);
    assign locked  = idle && (heat_dem || cool_dem) && (dwell < OFF_LIM);

`ifdef AC_FAN_EN
    localparam logic [DWELL_W:0] FAN_LIM = (DWELL_W + 1)'(FAN_OVERRUN);

    logic ran;

    // Remembers that the plant has run since reset so the overrun only follows real activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            ran <= 1'b0;
        end else if ((next_state != state) && (next_state != ST_IDLE)) begin
            ran <= 1'b1;
        end
    end

    assign fan = heating || cooling || (idle && ran && ({1'b0, dwell} < FAN_LIM));
`endif

endmodule

// File: tb/tb_ac_zone_ctrl.sv
// Testbench for ac_zone_ctrl: directed scenarios plus a random walk, checked
// against a behavioural model through an expected-output queue.
module tb_ac_zone_ctrl;

    localparam int TEMP_W      = 5;
    localparam int HYST_W      = 3;
    localparam int DWELL_W     = 8;
    localparam int MIN_ON      = 4;
    localparam int MIN_OFF     = 3;
    localparam int FAN_OVERRUN = 2;
    localparam int DWELL_MAX   = (1 << DWELL_W) - 1;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [TEMP_W-1:0] temperature;
    logic [TEMP_W-1:0] setpoint;
    logic [HYST_W-1:0] hyst;
    logic              heating;
    logic              cooling;
    logic              idle;
    logic              locked;
`ifdef AC_FAN_EN
    logic              fan;
`endif

    ac_zone_ctrl #(
        .TEMP_W(TEMP_W), .HYST_W(HYST_W), .DWELL_W(DWELL_W),
        .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .FAN_OVERRUN(FAN_OVERRUN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .temperature(temperature),
        .setpoint(setpoint),
        .hyst(hyst),
        .heating(heating),
        .cooling(cooling),
        .idle(idle),
        .locked(locked)
`ifdef AC_FAN_EN
        ,
        .fan(fan)
`endif
    );

    typedef struct {
        bit heating;
        bit cooling;
        bit idle;
        bit locked;
        bit fan;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    int check_count = 0;
    int pass_count  = 0;
    int cyc_count   = 0;

    // Reference model: mode 0=idle 1=heat 2=cool, time spent in the current mode.
    int m_mode  = 0;
    int m_since = DWELL_MAX;
    bit m_ran   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic act, input bit expv, input int cyc);
        check_count++;
        if (act === expv) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, act, expv);
        end
    endtask

    // Drives one cycle of inputs, advances the model over the coming edge and queues its outputs.
    task automatic applyStimulus(input bit r, input bit en, input int t, input int sp, input int h);
        exp_t e;
        bit   heat;
        bit   cool;
        int   new_mode;
        @(negedge clk);
        rst         = r;
        enable      = en;
        temperature = TEMP_W'(t);
        setpoint    = TEMP_W'(sp);
        hyst        = HYST_W'(h);
        heat = (t + h <= sp) && (t < sp);
        cool = (t >= sp + h) && (t > sp);
        if (r) begin
            m_mode  = 0;
            m_since = DWELL_MAX;
            m_ran   = 0;
        end else if (!en) begin
            m_mode  = 0;
            m_since = 0;
        end else begin
            new_mode = m_mode;
            if (m_mode == 0 && m_since >= MIN_OFF - 1) begin
                if (heat) new_mode = 1;
                else if (cool) new_mode = 2;
            end else if (m_mode == 1 && t >= sp && m_since >= MIN_ON - 1) begin
                new_mode = 0;
            end else if (m_mode == 2 && t <= sp && m_since >= MIN_ON - 1) begin
                new_mode = 0;
            end
            if (new_mode != m_mode) begin
                m_since = 0;
                if (new_mode != 0) m_ran = 1;
            end else if (m_since < DWELL_MAX) begin
                m_since++;
            end
            m_mode = new_mode;
        end
        cyc_count++;
        e.heating = (m_mode == 1);
        e.cooling = (m_mode == 2);
        e.idle    = (m_mode == 0);
        e.locked  = (m_mode == 0) && (heat || cool) && (m_since < MIN_OFF - 1);
        e.fan     = (m_mode != 0) || (m_ran && m_since < FAN_OVERRUN);
        e.cyc     = cyc_count;
        exp_q.push_back(e);
    endtask

    task automatic hold(input bit r, input bit en, input int t, input int sp, input int h, input int n);
        for (int i = 0; i < n; i++) applyStimulus(r, en, t, sp, h);
    endtask

    // Monitor: compares DUT outputs shortly after each edge against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("heating", heating, e.heating, e.cyc);
                checkOutput("cooling", cooling, e.cooling, e.cyc);
                checkOutput("idle", idle, e.idle, e.cyc);
                checkOutput("locked", locked, e.locked, e.cyc);
`ifdef AC_FAN_EN
                checkOutput("fan", fan, e.fan, e.cyc);
`endif
            end
        end
    end

    // Stimulus: directed scenarios first, then a bounded random walk around the setpoint.
    initial begin
        int tv;
        int sp;
        int h;
        rst         = 1'b1;
        enable      = 1'b0;
        temperature = '0;
        setpoint    = '0;
        hyst        = '0;

        $display("[TB] directed scenarios");
        hold(1, 1, 20, 20, 2, 2);
        hold(0, 1, 18, 20, 2, 4);
        hold(0, 1, 20, 20, 2, 3);

        hold(1, 1, 20, 20, 2, 1);
        hold(0, 1, 18, 20, 2, 1);
        hold(0, 1, 25, 20, 2, 10);

        hold(1, 1, 0, 1, 2, 1);
        hold(0, 1, 0, 1, 2, 5);
        hold(0, 1, 31, 30, 3, 5);

        hold(1, 1, 20, 20, 0, 1);
        hold(0, 1, 20, 20, 0, 3);
        hold(0, 1, 19, 20, 0, 6);
        hold(0, 1, 21, 20, 0, 10);

        hold(1, 1, 20, 20, 2, 1);
        hold(0, 1, 22, 20, 2, 2);
        hold(0, 0, 22, 20, 2, 1);
        hold(0, 1, 20, 20, 2, 3);
        hold(0, 1, 17, 20, 2, 3);
        hold(1, 1, 17, 20, 2, 1);
        hold(0, 1, 17, 20, 2, 3);

        hold(1, 1, 20, 20, 2, 1);
        hold(0, 1, 22, 20, 2, 1);
        hold(0, 1, 21, 20, 2, 3);
        hold(0, 1, 20, 20, 2, 5);
        hold(1, 1, 20, 20, 2, 2);

        $display("[TB] random walk");
        tv = 20;
        sp = 20;
        h  = 2;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) sp = $urandom_range(0, 31);
            if ($urandom_range(0, 39) == 0) h = $urandom_range(0, 7);
            tv = tv + $urandom_range(0, 4) - 2;
            if (tv < 0) tv = 0;
            if (tv > 31) tv = 31;
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 29) != 0, tv, sp, h);
        end

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            check_count++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
